// File: rtl/rv32i_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_pkg
//   Shared RV32I decode definitions: opcode and funct constants, ALU operation
//   and write-back select encodings, the packed control bundle handed from ID
//   to EX (ctrl_t, 16 bits) and its idle value CTRL_NOP.
//   No ports; imported by id_decoder and id_stage.
// -----------------------------------------------------------------------------
package rv32i_pkg;

   // Major opcodes (instr[6:0])
   localparam logic [6:0] OP_LUI      = 7'b0110111;
   localparam logic [6:0] OP_AUIPC    = 7'b0010111;
   localparam logic [6:0] OP_JAL      = 7'b1101111;
   localparam logic [6:0] OP_JALR     = 7'b1100111;
   localparam logic [6:0] OP_BRANCH   = 7'b1100011;
   localparam logic [6:0] OP_LOAD     = 7'b0000011;
   localparam logic [6:0] OP_STORE    = 7'b0100011;
   localparam logic [6:0] OP_IMM      = 7'b0010011;
   localparam logic [6:0] OP_OP       = 7'b0110011;
   localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

   // funct3 values of the integer ALU group
   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   // funct7 values: base encoding and the SUB/SRA alternate
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_e;

   typedef enum logic [1:0] {
      SRC_A_RS1  = 2'd0,
      SRC_A_PC   = 2'd1,
      SRC_A_ZERO = 2'd2
   } src_a_e;

   typedef enum logic [1:0] {
      WB_NONE = 2'd0,
      WB_ALU  = 2'd1,
      WB_MEM  = 2'd2,
      WB_PC4  = 2'd3
   } wb_sel_e;

   // 4 + 2 + 1 + 1 + 1 + 3 + 1 + 1 + 2 = 16 bits.
   // funct3 carries the load/store size or the branch comparison to EX.
   typedef struct packed {
      alu_op_e    alu_op;
      src_a_e     src_a;
      logic       src_b_imm;
      logic       mem_rd;
      logic       mem_wr;
      logic [2:0] funct3;
      logic       branch;
      logic       jump;
      wb_sel_e    wb_sel;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '{
      alu_op:    ALU_ADD,
      src_a:     SRC_A_RS1,
      src_b_imm: 1'b0,
      mem_rd:    1'b0,
      mem_wr:    1'b0,
      funct3:    3'b000,
      branch:    1'b0,
      jump:      1'b0,
      wb_sel:    WB_NONE
   };

   // Map funct3 (plus the instr[30] alternate bit) onto an ALU operation.
   function automatic alu_op_e alu_from_funct(input logic [2:0] f3, input logic alt);
      alu_op_e op;
      case (f3)
         F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
         F3_SLL:     op = ALU_SLL;
         F3_SLT:     op = ALU_SLT;
         F3_SLTU:    op = ALU_SLTU;
         F3_XOR:     op = ALU_XOR;
         F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
         F3_OR:      op = ALU_OR;
         F3_AND:     op = ALU_AND;
         default:    op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/id_decoder.sv
// -----------------------------------------------------------------------------
// id_decoder
//   Purely combinational RV32I decoder.
//   Ports:
//     instr    in  32  instruction word
//     ctrl     out 16  control bundle (CTRL_NOP when illegal)
//     imm      out 32  sign-extended immediate selected by opcode (0 for R type)
//     rd       out 5   destination register, 0 when rd is not written
//     uses_rs1 out 1   instruction reads rs1
//     uses_rs2 out 1   instruction reads rs2 (R, S and B types only)
//     illegal  out 1   opcode/funct combination outside the RV32I base set
// -----------------------------------------------------------------------------
module id_decoder
   import rv32i_pkg::*;
(
   input  logic [31:0] instr,
   output ctrl_t       ctrl,
   output logic [31:0] imm,
   output logic [4:0]  rd,
   output logic        uses_rs1,
   output logic        uses_rs2,
   output logic        illegal
);

   logic [6:0]  opcode_s;
   logic [2:0]  funct3_s;
   logic [6:0]  funct7_s;
   logic [31:0] imm_i_s;
   logic [31:0] imm_s_s;
   logic [31:0] imm_b_s;
   logic [31:0] imm_u_s;
   logic [31:0] imm_j_s;
   logic        load_f3_ok_s;
   logic        shift_imm_ok_s;
   logic        op_funct_ok_s;

   ctrl_t       ctrl_raw_s;
   logic [31:0] imm_sel_s;
   logic        writes_rd_s;
   logic        uses_rs1_raw_s;
   logic        uses_rs2_raw_s;
   logic        illegal_s;

   assign opcode_s = instr[6:0];
   assign funct3_s = instr[14:12];
   assign funct7_s = instr[31:25];

   assign imm_i_s = {{20{instr[31]}}, instr[31:20]};
   assign imm_s_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u_s = {instr[31:12], 12'b0};
   assign imm_j_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   // LB/LH/LW/LBU/LHU only
   assign load_f3_ok_s   = (funct3_s != 3'b011) && (funct3_s != 3'b110) && (funct3_s != 3'b111);
   // Shift-immediates reuse imm[11:5] as funct7; SRAI is the only alternate form.
   assign shift_imm_ok_s = (funct3_s == F3_SLL)     ? (funct7_s == F7_BASE) :
                           (funct3_s == F3_SRL_SRA) ? ((funct7_s == F7_BASE) || (funct7_s == F7_ALT)) :
                           1'b1;
   assign op_funct_ok_s  = (funct7_s == F7_BASE) ||
                           ((funct7_s == F7_ALT) && ((funct3_s == F3_ADD_SUB) || (funct3_s == F3_SRL_SRA)));

   // Per-opcode control, immediate and register-usage decode
   always_comb begin
      ctrl_raw_s     = CTRL_NOP;
      imm_sel_s      = 32'd0;
      writes_rd_s    = 1'b0;
      uses_rs1_raw_s = 1'b0;
      uses_rs2_raw_s = 1'b0;
      illegal_s      = 1'b0;
      case (opcode_s)
         OP_LUI: begin
            ctrl_raw_s.src_a     = SRC_A_ZERO;
            ctrl_raw_s.src_b_imm = 1'b1;
            ctrl_raw_s.wb_sel    = WB_ALU;
            imm_sel_s            = imm_u_s;
            writes_rd_s          = 1'b1;
         end
         OP_AUIPC: begin
            ctrl_raw_s.src_a     = SRC_A_PC;
            ctrl_raw_s.src_b_imm = 1'b1;
            ctrl_raw_s.wb_sel    = WB_ALU;
            imm_sel_s            = imm_u_s;
            writes_rd_s          = 1'b1;
         end
         OP_JAL: begin
            // ALU forms the target pc+imm; rd gets pc+4
            ctrl_raw_s.src_a     = SRC_A_PC;
            ctrl_raw_s.src_b_imm = 1'b1;
            ctrl_raw_s.jump      = 1'b1;
            ctrl_raw_s.wb_sel    = WB_PC4;
            imm_sel_s            = imm_j_s;
            writes_rd_s          = 1'b1;
         end
         OP_JALR: begin
            if (funct3_s == 3'b000) begin
               ctrl_raw_s.src_b_imm = 1'b1;
               ctrl_raw_s.jump      = 1'b1;
               ctrl_raw_s.wb_sel    = WB_PC4;
               imm_sel_s            = imm_i_s;
               writes_rd_s          = 1'b1;
               uses_rs1_raw_s       = 1'b1;
            end else begin
               illegal_s = 1'b1;
            end
         end
         OP_BRANCH: begin
            if ((funct3_s != 3'b010) && (funct3_s != 3'b011)) begin
               ctrl_raw_s.alu_op = ALU_SUB;
               ctrl_raw_s.funct3 = funct3_s;
               ctrl_raw_s.branch = 1'b1;
               imm_sel_s         = imm_b_s;
               uses_rs1_raw_s    = 1'b1;
               uses_rs2_raw_s    = 1'b1;
            end else begin
               illegal_s = 1'b1;
            end
         end
         OP_LOAD: begin
            if (load_f3_ok_s) begin
               ctrl_raw_s.src_b_imm = 1'b1;
               ctrl_raw_s.mem_rd    = 1'b1;
               ctrl_raw_s.funct3    = funct3_s;
               ctrl_raw_s.wb_sel    = WB_MEM;
               imm_sel_s            = imm_i_s;
               writes_rd_s          = 1'b1;
               uses_rs1_raw_s       = 1'b1;
            end else begin
               illegal_s = 1'b1;
            end
         end
         OP_STORE: begin
            if (funct3_s <= 3'b010) begin
               ctrl_raw_s.src_b_imm = 1'b1;
               ctrl_raw_s.mem_wr    = 1'b1;
               ctrl_raw_s.funct3    = funct3_s;
               imm_sel_s            = imm_s_s;
               uses_rs1_raw_s       = 1'b1;
               uses_rs2_raw_s       = 1'b1;
            end else begin
               illegal_s = 1'b1;
            end
         end
         OP_IMM: begin
            if (shift_imm_ok_s) begin
               // instr[30] is an immediate bit for ADDI, only SRAI treats it as funct7
               ctrl_raw_s.alu_op    = alu_from_funct(funct3_s, (funct3_s == F3_SRL_SRA) && instr[30]);
               ctrl_raw_s.src_b_imm = 1'b1;
               ctrl_raw_s.wb_sel    = WB_ALU;
               imm_sel_s            = imm_i_s;
               writes_rd_s          = 1'b1;
               uses_rs1_raw_s       = 1'b1;
            end else begin
               illegal_s = 1'b1;
            end
         end
         OP_OP: begin
            if (op_funct_ok_s) begin
               ctrl_raw_s.alu_op = alu_from_funct(funct3_s, instr[30]);
               ctrl_raw_s.wb_sel = WB_ALU;
               writes_rd_s       = 1'b1;
               uses_rs1_raw_s    = 1'b1;
               uses_rs2_raw_s    = 1'b1;
            end else begin
               illegal_s = 1'b1;
            end
         end
         // FENCE / ECALL / EBREAK pass as no-ops without a register write
         OP_MISC_MEM: illegal_s = 1'b0;
         OP_SYSTEM:   illegal_s = 1'b0;
         default:     illegal_s = 1'b1;
      endcase
   end

   assign ctrl     = illegal_s ? CTRL_NOP : ctrl_raw_s;
   assign imm      = imm_sel_s;
   assign rd       = (writes_rd_s && !illegal_s) ? instr[11:7] : 5'd0;
   assign uses_rs1 = uses_rs1_raw_s && !illegal_s;
   assign uses_rs2 = uses_rs2_raw_s && !illegal_s;
   assign illegal  = illegal_s;

endmodule

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage
//   RV32I decode stage sitting between fetch and EX. Drives the register-file
//   read addresses, merges read data with the write-back bypass, decodes the
//   instruction and holds it in the registered ID/EX slot (valid/ready).
//   Inserts one bubble on a load-use hazard and honours a flush from EX.
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     if_valid/if_ready          fetch handshake
//     if_instr, if_pc            fetched instruction and its pc
//     rf_raddr1/2, rf_rdata1/2   register-file read port (combinational data)
//     wb_we, wb_waddr, wb_wdata  write-back port, used for bypass
//     flush                      kill the slot and refuse the incoming instruction
//     ex_valid/ex_ready          EX handshake
//     ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_ctrl, ex_illegal
//                                registered ID/EX slot contents
// -----------------------------------------------------------------------------
module id_stage
   import rv32i_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_valid,
   output logic              if_ready,
   input  logic [31:0]       if_instr,
   input  logic [XLEN-1:0]   if_pc,
   output logic [4:0]        rf_raddr1,
   output logic [4:0]        rf_raddr2,
   input  logic [XLEN-1:0]   rf_rdata1,
   input  logic [XLEN-1:0]   rf_rdata2,
   input  logic              wb_we,
   input  logic [4:0]        wb_waddr,
   input  logic [XLEN-1:0]   wb_wdata,
   input  logic              flush,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_rs1_val,
   output logic [XLEN-1:0]   ex_rs2_val,
   output logic [XLEN-1:0]   ex_imm,
   output logic [4:0]        ex_rd,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic              ex_illegal
);

   // x0 always reads zero; otherwise the write-back value wins over the
   // register file, which only updates on the edge that captures the slot.
   function automatic logic [XLEN-1:0] bypass_operand(
      input logic [4:0]      addr,
      input logic [XLEN-1:0] rf_data,
      input logic            we,
      input logic [4:0]      waddr,
      input logic [XLEN-1:0] wdata
   );
      logic [XLEN-1:0] val;
      if (addr == 5'd0) begin
         val = '0;
      end else if (we && (waddr == addr)) begin
         val = wdata;
      end else begin
         val = rf_data;
      end
      return val;
   endfunction

   ctrl_t           dec_ctrl_s;
   logic [31:0]     dec_imm_s;
   logic [4:0]      dec_rd_s;
   logic            dec_uses_rs1_s;
   logic            dec_uses_rs2_s;
   logic            dec_illegal_s;

   logic [4:0]      rs1_addr_s;
   logic [4:0]      rs2_addr_s;
   logic [XLEN-1:0] rs1_val_s;
   logic [XLEN-1:0] rs2_val_s;
   logic            hz_s;
   logic            slot_free_s;
   logic            if_ready_s;
   logic            accept_s;

   logic            ex_valid_r;
   logic [XLEN-1:0] ex_pc_r;
   logic [XLEN-1:0] ex_rs1_val_r;
   logic [XLEN-1:0] ex_rs2_val_r;
   logic [XLEN-1:0] ex_imm_r;
   logic [4:0]      ex_rd_r;
   ctrl_t           ex_ctrl_r;
   logic            ex_illegal_r;

   id_decoder u_decoder (
      .instr    (if_instr),
      .ctrl     (dec_ctrl_s),
      .imm      (dec_imm_s),
      .rd       (dec_rd_s),
      .uses_rs1 (dec_uses_rs1_s),
      .uses_rs2 (dec_uses_rs2_s),
      .illegal  (dec_illegal_s)
   );

   assign rs1_addr_s = if_instr[19:15];
   assign rs2_addr_s = if_instr[24:20];
   assign rf_raddr1  = rs1_addr_s;
   assign rf_raddr2  = rs2_addr_s;

   assign rs1_val_s = bypass_operand(rs1_addr_s, rf_rdata1, wb_we, wb_waddr, wb_wdata);
   assign rs2_val_s = bypass_operand(rs2_addr_s, rf_rdata2, wb_we, wb_waddr, wb_wdata);

   // A load in the slot whose result the incoming instruction needs; its data
   // only exists after MEM, so the consumer must wait one cycle.
   assign hz_s = if_valid && ex_valid_r && ex_ctrl_r.mem_rd && (ex_rd_r != 5'd0) &&
                 ((dec_uses_rs1_s && (rs1_addr_s == ex_rd_r)) ||
                  (dec_uses_rs2_s && (rs2_addr_s == ex_rd_r)));

   assign slot_free_s = !ex_valid_r || ex_ready;
   assign if_ready_s  = !reset && slot_free_s && !hz_s && !flush;
   assign accept_s    = if_valid && if_ready_s;
   assign if_ready    = if_ready_s;

   // ID/EX slot: flush beats accept beats drain; otherwise everything holds
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid_r   <= 1'b0;
         ex_pc_r      <= '0;
         ex_rs1_val_r <= '0;
         ex_rs2_val_r <= '0;
         ex_imm_r     <= '0;
         ex_rd_r      <= 5'd0;
         ex_ctrl_r    <= CTRL_NOP;
         ex_illegal_r <= 1'b0;
      end else if (flush) begin
         ex_valid_r <= 1'b0;
      end else if (accept_s) begin
         ex_valid_r   <= 1'b1;
         ex_pc_r      <= if_pc;
         ex_rs1_val_r <= rs1_val_s;
         ex_rs2_val_r <= rs2_val_s;
         ex_imm_r     <= dec_imm_s;
         ex_rd_r      <= dec_rd_s;
         ex_ctrl_r    <= dec_ctrl_s;
         ex_illegal_r <= dec_illegal_s;
      end else if (ex_ready) begin
         // covers the load-use bubble as well as a plain drain
         ex_valid_r <= 1'b0;
      end
   end

   assign ex_valid   = ex_valid_r;
   assign ex_pc      = ex_pc_r;
   assign ex_rs1_val = ex_rs1_val_r;
   assign ex_rs2_val = ex_rs2_val_r;
   assign ex_imm     = ex_imm_r;
   assign ex_rd      = ex_rd_r;
   assign ex_ctrl    = ex_ctrl_r;
   assign ex_illegal = ex_illegal_r;

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage
//   Self-checking bench for id_stage: a table of single-instruction vectors
//   with hand-computed results, then directed sequences for load-use stalls,
//   backpressure, back-to-back issue, flush and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_id_stage;
   import rv32i_pkg::*;

   logic        clk;
   logic        reset;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [4:0]  rf_raddr1;
   logic [4:0]  rf_raddr2;
   logic [31:0] rf_rdata1;
   logic [31:0] rf_rdata2;
   logic        wb_we;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;
   logic        flush;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_pc;
   logic [31:0] ex_rs1_val;
   logic [31:0] ex_rs2_val;
   logic [31:0] ex_imm;
   logic [4:0]  ex_rd;
   logic [15:0] ex_ctrl;
   logic        ex_illegal;

   ctrl_t       ex_ctrl_f;
   logic [31:0] rf [32];

   int n_checks = 0;
   int n_errors = 0;

   id_stage #(.XLEN(32), .CTRL_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .if_valid   (if_valid),
      .if_ready   (if_ready),
      .if_instr   (if_instr),
      .if_pc      (if_pc),
      .rf_raddr1  (rf_raddr1),
      .rf_raddr2  (rf_raddr2),
      .rf_rdata1  (rf_rdata1),
      .rf_rdata2  (rf_rdata2),
      .wb_we      (wb_we),
      .wb_waddr   (wb_waddr),
      .wb_wdata   (wb_wdata),
      .flush      (flush),
      .ex_valid   (ex_valid),
      .ex_ready   (ex_ready),
      .ex_pc      (ex_pc),
      .ex_rs1_val (ex_rs1_val),
      .ex_rs2_val (ex_rs2_val),
      .ex_imm     (ex_imm),
      .ex_rd      (ex_rd),
      .ex_ctrl    (ex_ctrl),
      .ex_illegal (ex_illegal)
   );

   // Register-file model; x0 holds garbage so the stage's own zeroing is visible.
   assign rf_rdata1 = rf[rf_raddr1];
   assign rf_rdata2 = rf[rf_raddr2];
   assign ex_ctrl_f = ctrl_t'(ex_ctrl);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        wb_we;
      logic [4:0]  wb_waddr;
      logic [31:0] wb_wdata;
      logic        chk_imm;
      logic [31:0] e_imm;
      logic [4:0]  e_rd;
      logic [31:0] e_rs1;
      logic [31:0] e_rs2;
      logic        e_ill;
      alu_op_e     e_alu;
      wb_sel_e     e_wb;
      logic [3:0]  e_flags;   // {mem_rd, mem_wr, branch, jump}
   } vec_t;

   localparam int NVEC = 15;
   vec_t vec [NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [31:0] instr, input logic [31:0] pc);
      if_valid = 1'b1;
      if_instr = instr;
      if_pc    = pc;
   endtask

   localparam logic [31:0] I_ADDI_X1_5  = 32'h0050_0093;
   localparam logic [31:0] I_LW_X5      = 32'h0001_2283;
   localparam logic [31:0] I_ADD_X6_X5  = 32'h0012_8333;
   localparam logic [31:0] I_SW_X5_M8   = 32'hFE53_AC23;
   localparam logic [31:0] I_LUI_X5     = 32'h1234_52B7;
   localparam logic [31:0] I_SUB_X7     = 32'h4020_83B3;
   localparam logic [31:0] I_BEQ_M4     = 32'hFE20_8EE3;

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
      rf[0] = 32'h5555_5555;
      rf[3] = 32'h0000_0000;

      //          instr          pc            we    wa     wdata          ci    imm            rd     rs1            rs2            ill   alu       wb       flags
      vec[0]  = '{32'h0050_0093, 32'h0000_0100, 1'b0, 5'd0, 32'h0,         1'b1, 32'h0000_0005, 5'd1, 32'h0,         32'h1000_0005, 1'b0, ALU_ADD,  WB_ALU,  4'b0000};
      vec[1]  = '{32'h0031_8233, 32'h0000_0104, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1, 32'h0,         5'd4, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, ALU_ADD,  WB_ALU,  4'b0000};
      vec[2]  = '{32'h0031_8233, 32'h0000_0108, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 32'h0,         5'd4, 32'h0,         32'h0,         1'b0, ALU_ADD,  WB_ALU,  4'b0000};
      vec[3]  = '{32'h0020_0233, 32'h0000_010C, 1'b1, 5'd2, 32'hCAFE_F00D, 1'b1, 32'h0,         5'd4, 32'h0,         32'hCAFE_F00D, 1'b0, ALU_ADD,  WB_ALU,  4'b0000};
      vec[4]  = '{32'h0020_0233, 32'h0000_0110, 1'b0, 5'd2, 32'hCAFE_F00D, 1'b1, 32'h0,         5'd4, 32'h0,         32'h1000_0002, 1'b0, ALU_ADD,  WB_ALU,  4'b0000};
      vec[5]  = '{32'h4020_83B3, 32'h0000_0114, 1'b0, 5'd0, 32'h0,         1'b1, 32'h0,         5'd7, 32'h1000_0001, 32'h1000_0002, 1'b0, ALU_SUB,  WB_ALU,  4'b0000};
      vec[6]  = '{32'h4040_D193, 32'h0000_0118, 1'b0, 5'd0, 32'h0,         1'b1, 32'h0000_0404, 5'd3, 32'h1000_0001, 32'h1000_0004, 1'b0, ALU_SRA,  WB_ALU,  4'b0000};
      vec[7]  = '{32'h0001_2283, 32'h0000_011C, 1'b0, 5'd0, 32'h0,         1'b1, 32'h0,         5'd5, 32'h1000_0002, 32'h0,         1'b0, ALU_ADD,  WB_MEM,  4'b1000};
      vec[8]  = '{32'hFE53_AC23, 32'h0000_0120, 1'b0, 5'd0, 32'h0,         1'b1, 32'hFFFF_FFF8, 5'd0, 32'h1000_0007, 32'h1000_0005, 1'b0, ALU_ADD,  WB_NONE, 4'b0100};
      vec[9]  = '{32'hFE20_8EE3, 32'h0000_0124, 1'b0, 5'd0, 32'h0,         1'b1, 32'hFFFF_FFFC, 5'd0, 32'h1000_0001, 32'h1000_0002, 1'b0, ALU_SUB,  WB_NONE, 4'b0010};
      vec[10] = '{32'h0010_00EF, 32'h0000_0128, 1'b0, 5'd0, 32'h0,         1'b1, 32'h0000_0800, 5'd1, 32'h0,         32'h1000_0001, 1'b0, ALU_ADD,  WB_PC4,  4'b0001};
      vec[11] = '{32'h1234_52B7, 32'h0000_012C, 1'b0, 5'd0, 32'h0,         1'b1, 32'h1234_5000, 5'd5, 32'h1000_0008, 32'h0,         1'b0, ALU_ADD,  WB_ALU,  4'b0000};
      vec[12] = '{32'hFFFF_F117, 32'h0000_0130, 1'b0, 5'd0, 32'h0,         1'b1, 32'hFFFF_F000, 5'd2, 32'h1000_001F, 32'h1000_001F, 1'b0, ALU_ADD,  WB_ALU,  4'b0000};
      vec[13] = '{32'hFFFF_FFFF, 32'h0000_0134, 1'b0, 5'd0, 32'h0,         1'b0, 32'h0,         5'd0, 32'h1000_001F, 32'h1000_001F, 1'b1, ALU_ADD,  WB_NONE, 4'b0000};
      vec[14] = '{32'h4000_1033, 32'h0000_0138, 1'b0, 5'd0, 32'h0,         1'b0, 32'h0,         5'd0, 32'h0,         32'h0,         1'b1, ALU_ADD,  WB_NONE, 4'b0000};

      // ---------------- reset ----------------
      reset    = 1'b1;
      if_valid = 1'b1;
      if_instr = I_ADDI_X1_5;
      if_pc    = 32'h0;
      wb_we    = 1'b0;
      wb_waddr = 5'd0;
      wb_wdata = 32'h0;
      flush    = 1'b0;
      ex_ready = 1'b1;
      tick();
      tick();
      check("reset_if_ready", 32'(if_ready), 32'd0);
      check("reset_ex_valid", 32'(ex_valid), 32'd0);
      check("reset_ex_pc", ex_pc, 32'h0);
      check("reset_ex_rs1", ex_rs1_val, 32'h0);
      check("reset_ex_rs2", ex_rs2_val, 32'h0);
      check("reset_ex_imm", ex_imm, 32'h0);
      check("reset_ex_rd", 32'(ex_rd), 32'd0);
      check("reset_ex_ctrl", 32'(ex_ctrl), 32'(CTRL_NOP));
      check("reset_ex_illegal", 32'(ex_illegal), 32'd0);
      reset    = 1'b0;
      if_valid = 1'b0;
      tick();

      // ---------------- vector table ----------------
      for (int i = 0; i < NVEC; i++) begin
         present(vec[i].instr, vec[i].pc);
         wb_we    = vec[i].wb_we;
         wb_waddr = vec[i].wb_waddr;
         wb_wdata = vec[i].wb_wdata;
         #1;
         check($sformatf("v%0d_if_ready", i), 32'(if_ready), 32'd1);
         tick();
         check($sformatf("v%0d_ex_valid", i), 32'(ex_valid), 32'd1);
         check($sformatf("v%0d_ex_pc", i), ex_pc, vec[i].pc);
         if (vec[i].chk_imm) check($sformatf("v%0d_ex_imm", i), ex_imm, vec[i].e_imm);
         check($sformatf("v%0d_ex_rd", i), 32'(ex_rd), 32'(vec[i].e_rd));
         check($sformatf("v%0d_ex_rs1", i), ex_rs1_val, vec[i].e_rs1);
         check($sformatf("v%0d_ex_rs2", i), ex_rs2_val, vec[i].e_rs2);
         check($sformatf("v%0d_ex_illegal", i), 32'(ex_illegal), 32'(vec[i].e_ill));
         check($sformatf("v%0d_alu_op", i), 32'(ex_ctrl_f.alu_op), 32'(vec[i].e_alu));
         check($sformatf("v%0d_wb_sel", i), 32'(ex_ctrl_f.wb_sel), 32'(vec[i].e_wb));
         check($sformatf("v%0d_flags", i),
               32'({ex_ctrl_f.mem_rd, ex_ctrl_f.mem_wr, ex_ctrl_f.branch, ex_ctrl_f.jump}),
               32'(vec[i].e_flags));
         if (vec[i].e_ill) check($sformatf("v%0d_ctrl_nop", i), 32'(ex_ctrl), 32'(CTRL_NOP));
         if_valid = 1'b0;
         wb_we    = 1'b0;
         tick();
      end

      // ---------------- load-use: LW x5 then ADD x6,x5,x1 ----------------
      present(I_LW_X5, 32'h0000_0200);
      tick();
      present(I_ADD_X6_X5, 32'h0000_0204);
      #1;
      check("lu_ex_valid_load", 32'(ex_valid), 32'd1);
      check("lu_if_ready_stall", 32'(if_ready), 32'd0);
      tick();
      check("lu_bubble", 32'(ex_valid), 32'd0);
      check("lu_if_ready_after", 32'(if_ready), 32'd1);
      tick();
      check("lu_add_valid", 32'(ex_valid), 32'd1);
      check("lu_add_rd", 32'(ex_rd), 32'd6);
      check("lu_add_pc", ex_pc, 32'h0000_0204);
      check("lu_add_rs1", ex_rs1_val, 32'h1000_0005);
      if_valid = 1'b0;
      tick();

      // SW x5 (rs2 = x5) after LW x5 stalls
      present(I_LW_X5, 32'h0000_0210);
      tick();
      present(I_SW_X5_M8, 32'h0000_0214);
      #1;
      check("lu_sw_stall", 32'(if_ready), 32'd0);
      if_valid = 1'b0;
      tick();

      // LUI x5 after LW x5 does not stall
      present(I_LW_X5, 32'h0000_0220);
      tick();
      present(I_LUI_X5, 32'h0000_0224);
      #1;
      check("lu_lui_no_stall", 32'(if_ready), 32'd1);
      tick();
      check("lu_lui_rd", 32'(ex_rd), 32'd5);
      if_valid = 1'b0;
      tick();

      // ADDI x1,x0,5 has 5 in the rs2 field but does not read rs2
      present(I_LW_X5, 32'h0000_0230);
      tick();
      present(I_ADDI_X1_5, 32'h0000_0234);
      #1;
      check("lu_itype_rs2_field", 32'(if_ready), 32'd1);
      tick();
      if_valid = 1'b0;
      tick();

      // ---------------- backpressure ----------------
      present(I_ADDI_X1_5, 32'h0000_0300);
      tick();
      ex_ready = 1'b0;
      present(I_SUB_X7, 32'h0000_0304);
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("bp%0d_if_ready", c), 32'(if_ready), 32'd0);
         tick();
         check($sformatf("bp%0d_valid", c), 32'(ex_valid), 32'd1);
         check($sformatf("bp%0d_pc", c), ex_pc, 32'h0000_0300);
         check($sformatf("bp%0d_rd", c), 32'(ex_rd), 32'd1);
         check($sformatf("bp%0d_imm", c), ex_imm, 32'h0000_0005);
      end
      ex_ready = 1'b1;
      #1;
      check("bp_release_if_ready", 32'(if_ready), 32'd1);
      tick();
      check("bp_next_rd", 32'(ex_rd), 32'd7);
      check("bp_next_pc", ex_pc, 32'h0000_0304);

      // ---------------- back-to-back issue ----------------
      present(I_ADDI_X1_5, 32'h0000_0308);
      tick();
      check("tp0_valid", 32'(ex_valid), 32'd1);
      check("tp0_pc", ex_pc, 32'h0000_0308);
      present(I_SW_X5_M8, 32'h0000_030C);
      tick();
      check("tp1_valid", 32'(ex_valid), 32'd1);
      check("tp1_pc", ex_pc, 32'h0000_030C);
      check("tp1_rd", 32'(ex_rd), 32'd0);

      // ---------------- flush ----------------
      present(I_BEQ_M4, 32'h0000_0310);
      flush = 1'b1;
      #1;
      check("fl_if_ready", 32'(if_ready), 32'd0);
      tick();
      check("fl_ex_valid", 32'(ex_valid), 32'd0);
      flush = 1'b0;
      #1;
      check("fl_after_if_ready", 32'(if_ready), 32'd1);
      tick();
      check("fl_refetch_valid", 32'(ex_valid), 32'd1);
      check("fl_refetch_pc", ex_pc, 32'h0000_0310);
      check("fl_refetch_imm", ex_imm, 32'hFFFF_FFFC);

      // ---------------- reset with a held instruction ----------------
      ex_ready = 1'b0;
      present(I_SUB_X7, 32'h0000_0320);
      reset = 1'b1;
      #1;
      check("rst_mid_if_ready", 32'(if_ready), 32'd0);
      tick();
      check("rst_mid_ex_valid", 32'(ex_valid), 32'd0);
      check("rst_mid_ex_pc", ex_pc, 32'h0);
      reset    = 1'b0;
      if_valid = 1'b0;
      ex_ready = 1'b1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
